out_signature_monitor: RTL and testbench

Downstream checker stage for the random-design DUT tops (e.g. `design239_7_8_top`). It consumes the DUT's `out` bus after a reset-recovery settle window and compacts a fixed number of samples into a MISR signature. It also counts output toggles. Benches and on-chip validation wrappers compare the final signature against a golden value instead of checking the trace cycle by cycle.

---
 rtl/sig_mon_pkg.sv | 23 ++
 rtl/out_signature_monitor_misr_reg.sv | 45 ++++
 rtl/out_signature_monitor.sv | 113 +++++++++++
 tb/tb_out_signature_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sig_mon_pkg.sv
// Shared types, default constants and the MISR step function for the
// output signature monitor and its golden models.
package sig_mon_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEFAULT_SEED = 32'h0000_0000;

   // One MISR update: shift left, fold in the polynomial when the MSB falls
   // out, then XOR the new sample.
   function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                             input logic [31:0] din,
                                             input logic [31:0] poly);
      return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ din;
   endfunction

endpackage

// File: rtl/out_signature_monitor_misr_reg.sv
// WIDTH-bit multiple-input signature register with seed load and enable.
module misr_reg
   import sig_mon_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] sig_reg;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] sig_next;

   // Left shift by one with a zero entering at bit 0.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
         assign shifted[gi] = 1'b0;
      end else begin : g_upper
         assign shifted[gi] = sig_reg[gi-1];
      end
   end

   assign sig_next = shifted ^ ({WIDTH{sig_reg[WIDTH-1]}} & POLY) ^ din;

   // Seed load takes priority over compaction so a run always starts clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_reg <= SEED;
      end else if (load) begin
         sig_reg <= SEED;
      end else if (en) begin
         sig_reg <= sig_next;
      end
   end

   assign sig = sig_reg;

endmodule

// File: rtl/out_signature_monitor.sv
// Compacts a DUT output bus into a MISR signature after a settle window and
// counts cycle-to-cycle changes of the bus during capture.
module out_signature_monitor
   import sig_mon_pkg::*;
#(
   parameter int               WIDTH          = 32,
   parameter int               SETTLE_CYCLES  = 8,
   parameter int               CAPTURE_CYCLES = 64,
   parameter logic [WIDTH-1:0] POLY           = WIDTH'(DEFAULT_POLY),
   parameter logic [WIDTH-1:0] SEED           = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] signature,
   output logic [15:0]      change_cnt
);

   localparam int MAX_CYCLES = (SETTLE_CYCLES > CAPTURE_CYCLES) ? SETTLE_CYCLES : CAPTURE_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
   // Terminal counts; SETTLE_LAST is unused when there is no settle window.
   localparam logic [CNT_W-1:0] SETTLE_LAST  = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] CAPTURE_LAST = CNT_W'(CAPTURE_CYCLES - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [15:0]      change_reg, change_next;
   logic [WIDTH-1:0] prev_in_reg;
   logic             busy_reg, done_reg;
   logic             misr_load, misr_en;

   // Next-state, phase counter and change counter; start only acts from IDLE/DONE.
   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      change_next = change_reg;
      misr_load   = 1'b0;
      misr_en     = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               state_next  = (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;
               cnt_next    = '0;
               change_next = 16'h0000;
               misr_load   = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt_reg == SETTLE_LAST) begin
               state_next = CAPTURE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         CAPTURE: begin
            misr_en = 1'b1;
            if ((in != prev_in_reg) && (change_reg != 16'hFFFF)) begin
               change_next = change_reg + 16'h0001;
            end
            if (cnt_reg == CAPTURE_LAST) begin
               state_next = DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, counters, previous sample and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         change_reg  <= 16'h0000;
         prev_in_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         change_reg  <= change_next;
         prev_in_reg <= in;
         busy_reg    <= (state_next == SETTLE) || (state_next == CAPTURE);
         done_reg    <= (state_next == DONE);
      end
   end

   misr_reg #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misr_load),
      .en   (misr_en),
      .din  (in),
      .sig  (signature)
   );

   assign busy       = busy_reg;
   assign done       = done_reg;
   assign change_cnt = change_reg;

endmodule

// File: tb/tb_out_signature_monitor.sv
// Directed bench for out_signature_monitor using four parameterisations.
module tb_out_signature_monitor;
   import sig_mon_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Impulse instance: no settle, 4 captures.
   logic        rst_imp = 1'b1, start_imp = 1'b0, busy_imp, done_imp;
   logic [31:0] in_imp = '0, sig_imp;
   logic [15:0] cc_imp;
   // Constant instance: settle 8, capture 1.
   logic        rst_cst = 1'b1, start_cst = 1'b0, busy_cst, done_cst;
   logic [31:0] in_cst = '0, sig_cst;
   logic [15:0] cc_cst;
   // Default-parameter instance.
   logic        rst_def = 1'b1, start_def = 1'b0, busy_def, done_def;
   logic [31:0] in_def = '0, sig_def;
   logic [15:0] cc_def;
   // Saturation instance: long capture, no settle.
   logic        rst_sat = 1'b1, start_sat = 1'b0, busy_sat, done_sat;
   logic [31:0] in_sat = '0, sig_sat;
   logic [15:0] cc_sat;

   out_signature_monitor #(.SETTLE_CYCLES(0), .CAPTURE_CYCLES(4)) u_imp (
      .clk(clk), .rst(rst_imp), .in(in_imp), .start(start_imp),
      .busy(busy_imp), .done(done_imp), .signature(sig_imp), .change_cnt(cc_imp));
   out_signature_monitor #(.SETTLE_CYCLES(8), .CAPTURE_CYCLES(1)) u_cst (
      .clk(clk), .rst(rst_cst), .in(in_cst), .start(start_cst),
      .busy(busy_cst), .done(done_cst), .signature(sig_cst), .change_cnt(cc_cst));
   out_signature_monitor u_def (
      .clk(clk), .rst(rst_def), .in(in_def), .start(start_def),
      .busy(busy_def), .done(done_def), .signature(sig_def), .change_cnt(cc_def));
   out_signature_monitor #(.SETTLE_CYCLES(0), .CAPTURE_CYCLES(65540)) u_sat (
      .clk(clk), .rst(rst_sat), .in(in_sat), .start(start_sat),
      .busy(busy_sat), .done(done_sat), .signature(sig_sat), .change_cnt(cc_sat));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stand-in for the DUT output trace: changes every third cycle.
   function automatic logic [31:0] trace_val(input int k);
      return 32'haaaaaaaa ^ (32'(k / 3) * 32'h9e3779b9);
   endfunction

   task automatic test_reset();
      rst_imp = 1'b1; rst_cst = 1'b1; rst_def = 1'b1; rst_sat = 1'b1;
      tick(); tick();
      rst_imp = 1'b0; rst_cst = 1'b0; rst_def = 1'b0; rst_sat = 1'b0;
      tick();
      checks++; if (busy_def !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_def); end
      checks++; if (done_def !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_def); end
      checks++; if (sig_def !== 32'h0) begin errors++; $display("FAIL reset_sig got %h want 0", sig_def); end
      checks++; if (cc_def !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", cc_def); end
      checks++; if (busy_imp !== 1'b0 || done_imp !== 1'b0) begin errors++; $display("FAIL reset_imp_flags got %b%b want 00", busy_imp, done_imp); end
      $display("reset: outputs idle");
   endtask

   task automatic test_impulse();
      in_imp = 32'h0; start_imp = 1'b1;
      tick();                          // start sampled; prev_in = 0
      start_imp = 1'b0;
      checks++; if (busy_imp !== 1'b1) begin errors++; $display("FAIL imp_busy got %b want 1", busy_imp); end
      for (int k = 1; k <= 4; k++) begin
         in_imp = (k == 1) ? 32'h1 : 32'h0;
         tick();
         checks++;
         if (done_imp !== (k == 4)) begin errors++; $display("FAIL imp_done_k%0d got %b want %b", k, done_imp, (k == 4)); end
      end
      checks++; if (busy_imp !== 1'b0) begin errors++; $display("FAIL imp_busy_end got %b want 0", busy_imp); end
      checks++; if (sig_imp !== 32'h8) begin errors++; $display("FAIL imp_sig got %h want 00000008", sig_imp); end
      checks++; if (cc_imp !== 16'd2) begin errors++; $display("FAIL imp_cnt got %0d want 2", cc_imp); end
      tick(); tick();
      checks++; if (done_imp !== 1'b1 || sig_imp !== 32'h8) begin errors++; $display("FAIL imp_hold got %b/%h want 1/00000008", done_imp, sig_imp); end
      $display("impulse: sig=%h cnt=%0d", sig_imp, cc_imp);
   endtask

   task automatic test_constant();
      int done_at;
      in_cst = 32'habcdefab;
      tick(); tick();
      start_cst = 1'b1;
      tick();
      start_cst = 1'b0;
      done_at = -1;
      for (int k = 2; k <= 20; k++) begin
         tick();
         if (done_cst === 1'b1 && done_at < 0) done_at = k;
      end
      checks++; if (done_at != 10) begin errors++; $display("FAIL cst_latency got %0d want 10", done_at); end
      checks++; if (sig_cst !== 32'habcdefab) begin errors++; $display("FAIL cst_sig got %h want abcdefab", sig_cst); end
      checks++; if (cc_cst !== 16'd0) begin errors++; $display("FAIL cst_cnt got %0d want 0", cc_cst); end
      $display("constant: sig=%h latency=%0d", sig_cst, done_at);
   endtask

   // Drives one run on u_def; optionally re-pulses start at tick restart_at.
   task automatic run_def(input int restart_at, output logic [31:0] sig,
                          output logic [15:0] cc, output int done_at);
      in_def = trace_val(0); start_def = 1'b1;
      tick();
      done_at = -1;
      for (int k = 1; k <= 80; k++) begin
         in_def    = trace_val(k);
         start_def = (k == restart_at);
         tick();
         if (done_def === 1'b1 && done_at < 0) done_at = k;
      end
      start_def = 1'b0;
      sig = sig_def;
      cc  = cc_def;
   endtask

   task automatic golden(output logic [31:0] sig, output logic [15:0] cc);
      sig = DEFAULT_SEED;
      cc  = 16'h0;
      for (int k = 9; k <= 72; k++) begin
         sig = misr_step(sig, trace_val(k), DEFAULT_POLY);
         if (trace_val(k) != trace_val(k - 1)) cc++;
      end
   endtask

   task automatic test_trace();
      logic [31:0] g_sig, s1, s2;
      logic [15:0] g_cc, c1, c2;
      int          d1, d2;
      golden(g_sig, g_cc);
      run_def(-1, s1, c1, d1);
      run_def(-1, s2, c2, d2);
      checks++; if (s1 !== g_sig) begin errors++; $display("FAIL trace_sig got %h want %h", s1, g_sig); end
      checks++; if (c1 !== g_cc) begin errors++; $display("FAIL trace_cnt got %0d want %0d", c1, g_cc); end
      checks++; if (d1 != 72) begin errors++; $display("FAIL trace_latency got %0d want 72", d1); end
      checks++; if (s2 !== s1 || c2 !== c1 || d2 != d1) begin errors++; $display("FAIL trace_repeat got %h/%0d/%0d want %h/%0d/%0d", s2, c2, d2, s1, c1, d1); end
      $display("trace: sig=%h cnt=%0d latency=%0d", s1, c1, d1);
   endtask

   task automatic test_restart_ignored();
      logic [31:0] g_sig, s;
      logic [15:0] g_cc, c;
      int          d;
      golden(g_sig, g_cc);
      run_def(30, s, c, d);
      checks++; if (s !== g_sig) begin errors++; $display("FAIL restart_sig got %h want %h", s, g_sig); end
      checks++; if (c !== g_cc) begin errors++; $display("FAIL restart_cnt got %0d want %0d", c, g_cc); end
      checks++; if (d != 72) begin errors++; $display("FAIL restart_latency got %0d want 72", d); end
      $display("restart: sig=%h latency=%0d", s, d);
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] g_sig, s;
      logic [15:0] g_cc, c;
      int          d;
      in_def = trace_val(0); start_def = 1'b1;
      tick();
      start_def = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         in_def = trace_val(k);
         tick();
      end
      rst_def = 1'b1;
      tick();
      rst_def = 1'b0;
      checks++; if (busy_def !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy_def); end
      checks++; if (done_def !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done_def); end
      checks++; if (sig_def !== 32'h0) begin errors++; $display("FAIL midrst_sig got %h want 0", sig_def); end
      checks++; if (cc_def !== 16'h0) begin errors++; $display("FAIL midrst_cnt got %0d want 0", cc_def); end
      golden(g_sig, g_cc);
      run_def(-1, s, c, d);
      checks++; if (s !== g_sig || d != 72) begin errors++; $display("FAIL midrst_rerun got %h/%0d want %h/72", s, d, g_sig); end
      $display("reset_mid_run: rerun sig=%h", s);
   endtask

   task automatic test_start_with_reset();
      rst_def = 1'b1; start_def = 1'b1;
      tick();
      rst_def = 1'b0; start_def = 1'b0;
      tick();
      checks++; if (busy_def !== 1'b0 || done_def !== 1'b0) begin errors++; $display("FAIL start_rst got %b%b want 00", busy_def, done_def); end
      $display("start_with_reset: busy=%b", busy_def);
   endtask

   task automatic test_saturation();
      int done_at;
      in_sat = 32'h0; start_sat = 1'b1;
      tick();
      start_sat = 1'b0;
      done_at = -1;
      for (int k = 1; k <= 65600 && done_at < 0; k++) begin
         in_sat = ~in_sat;
         tick();
         if (done_sat === 1'b1) done_at = k;
      end
      checks++; if (done_at != 65540) begin errors++; $display("FAIL sat_latency got %0d want 65540", done_at); end
      checks++; if (cc_sat !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got %h want ffff", cc_sat); end
      $display("saturation: cnt=%h latency=%0d", cc_sat, done_at);
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_constant();
      test_trace();
      test_restart_ignored();
      test_reset_mid_run();
      test_start_with_reset();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
